// File: rtl/seg7_multi_dec.sv
// rtl/seg7_multi_dec.sv - multi-digit game-state 7-segment decoder with timed reveal and leading-zero blanking
// Optional cursor blink: define SEG7_MULTI_BLINK_EN.
module seg7_multi_dec #(
    parameter int DIGITS    = 4,
    parameter int STEP_CYC  = 25_000_000,
    parameter int BLINK_CYC = 12_500_000
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [3:0]            STATE,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  LOAD,
    input  logic [2:0]            CURSOR,
    input  logic                  LZB,
    output logic [7*DIGITS-1:0]   nHEX,
    output logic                  DONE
);
    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;

    localparam int RW = $clog2(DIGITS + 1);
    localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [RW-1:0] R_FULL = RW'(DIGITS);
    localparam logic [TW-1:0] T_LAST = TW'(STEP_CYC - 1);

    logic [3:0]          r_state_q;
    logic                r_lzb_q;
    logic [4*DIGITS-1:0] r_val_q;
    logic [4*DIGITS-1:0] r_val_d;
    logic [RW-1:0]       r_rcnt;
    logic [TW-1:0]       r_timer;
    logic [7*DIGITS-1:0] r_nhex;
    logic                r_done;

    logic [7*DIGITS-1:0] w_nhex;
    logic [DIGITS-1:0]   w_blink_mask;
    logic [2:0]          w_msnz;
    logic                w_lz;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1011000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state_q <= 4'b0000;
            r_lzb_q   <= 1'b0;
            r_val_q   <= '0;
            r_val_d   <= '0;
            r_rcnt    <= '0;
            r_timer   <= '0;
            r_nhex    <= '1;
            r_done    <= 1'b0;
        end else begin
            r_state_q <= STATE;
            r_lzb_q   <= LZB;
            r_val_d   <= r_val_q;
            if (LOAD)
                r_val_q <= VALUE;
            // Entry edge and any non-QUESTION edge restart the reveal
            if (STATE != ST_QUESTION || r_state_q != ST_QUESTION) begin
                r_rcnt  <= '0;
                r_timer <= '0;
            end else if (r_rcnt != R_FULL) begin
                if (r_timer == T_LAST) begin
                    r_timer <= '0;
                    r_rcnt  <= r_rcnt + 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
            r_done <= (r_state_q == ST_QUESTION) && (r_rcnt == R_FULL);
            r_nhex <= w_nhex;
        end
    end

`ifdef SEG7_MULTI_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_CYC);
    localparam logic [BW-1:0] B_LAST = BW'(2 * BLINK_CYC - 1);
    localparam logic [BW-1:0] B_HALF = BW'(BLINK_CYC);

    logic [BW-1:0] r_blink;
    logic [2:0]    r_cursor_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_blink    <= '0;
            r_cursor_q <= 3'd0;
        end else begin
            r_cursor_q <= CURSOR;
            if (STATE != ST_INPUT || r_state_q != ST_INPUT || LOAD || CURSOR != r_cursor_q)
                r_blink <= '0;
            else if (r_blink == B_LAST)
                r_blink <= '0;
            else
                r_blink <= r_blink + 1'b1;
        end
    end

    always_comb begin
        w_blink_mask = '0;
        for (int i = 0; i < DIGITS; i++)
            if (r_state_q == ST_INPUT && r_blink >= B_HALF && r_cursor_q == 3'(i))
                w_blink_mask[i] = 1'b1;
    end
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^CURSOR;
    assign w_blink_mask    = '0;
`endif

    always_comb begin
        w_nhex = '1;
        w_msnz = 3'd0;
        w_lz   = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (r_val_d[4*i +: 4] != 4'd0)
                w_msnz = 3'(i);
        for (int i = 0; i < DIGITS; i++) begin
            // Digit 0 can never exceed the index of the top nonzero digit
            w_lz = r_lzb_q && (i > int'(w_msnz));
            case (r_state_q)
                ST_READY:    w_nhex[7*i +: 7] = 7'b0111111;
                ST_QUESTION: if (i >= DIGITS - int'(r_rcnt) && !w_lz)
                                 w_nhex[7*i +: 7] = glyph(r_val_d[4*i +: 4]);
                ST_INPUT:    if (!w_lz && !w_blink_mask[i])
                                 w_nhex[7*i +: 7] = glyph(r_val_d[4*i +: 4]);
                default:     ;
            endcase
        end
    end

    assign nHEX = r_nhex;
    assign DONE = r_done;
endmodule
